// File: rtl/load_resp_pkg.sv
// Shared types for the load responder: index/data widths, miss-queue entry, FSM states.
package load_resp_pkg;

   localparam int MEM_IDX_W = 8;
   localparam int LQ_IDX_W  = 4;
   localparam int BLK_W     = 32;

   typedef logic                 bool;
   typedef logic [MEM_IDX_W-1:0] mem_idx_t;
   typedef logic [LQ_IDX_W-1:0]  lq_idx_t;
   typedef logic [BLK_W-1:0]     mem_blk_t;

   // One pending miss: which block to fetch and which load-queue slot waits for it.
   typedef struct packed {
      mem_idx_t mem_idx;
      lq_idx_t  lq_idx;
   } mq_entry_t;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_REQ  = 2'd1,
      MEM_WAIT = 2'd2
   } mem_state_e;

   localparam mq_entry_t MQ_ENTRY_ZERO = '{mem_idx: 8'h00, lq_idx: 4'h0};
   localparam mem_blk_t  MEM_BLK_ZERO  = 32'h0000_0000;
   localparam mem_idx_t  MEM_IDX_ZERO  = 8'h00;
   localparam lq_idx_t   LQ_IDX_ZERO   = 4'h0;

   // Next slot in a ring of n entries (works for any n, not just powers of two).
   function automatic logic [31:0] ring_next(input logic [31:0] cur, input logic [31:0] n);
      if ((cur + 32'd1) >= n) begin
         ring_next = 32'd0;
      end else begin
         ring_next = cur + 32'd1;
      end
   endfunction

endpackage

// File: rtl/load_if.sv
// Load query/ack/hit/answer channel between the load queue and the responder.
interface load;
   import load_resp_pkg::*;

   bool      qry;
   mem_idx_t qry_mem_idx;
   lq_idx_t  qry_lq_idx;
   bool      ack;
   lq_idx_t  ack_head;
   bool      hit;
   mem_blk_t hit_blk;
   bool      ans;
   lq_idx_t  ans_head;
   mem_blk_t ans_blk;

   modport ds (
      input  qry, qry_mem_idx, qry_lq_idx,
      output ack, ack_head, hit, hit_blk, ans, ans_head, ans_blk
   );

   modport us (
      output qry, qry_mem_idx, qry_lq_idx,
      input  ack, ack_head, hit, hit_blk, ans, ans_head, ans_blk
   );
endinterface

// File: rtl/load_miss_fifo.sv
// Miss queue: ordered FIFO of outstanding misses; full/empty reflect pre-edge occupancy.
module load_miss_fifo
   import load_resp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push_i,
   input  mq_entry_t push_data_i,
   input  logic      pop_i,
   output logic      full_o,
   output logic      empty_o,
   output mq_entry_t head_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);

   mq_entry_t     mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push_s, do_pop_s;

   assign full_o    = (cnt_q == CW'(DEPTH));
   assign empty_o   = (cnt_q == {CW{1'b0}});
   assign do_push_s = push_i && !full_o;
   assign do_pop_s  = pop_i && !empty_o;
   assign head_o    = mem_q[head_q];

   // Pointer and occupancy next-state; pointers wrap at DEPTH.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (do_push_s) begin
         tail_d = PW'(ring_next(32'(tail_q), 32'(DEPTH)));
      end else begin
         tail_d = tail_q;
      end
      if (do_pop_s) begin
         head_d = PW'(ring_next(32'(head_q), 32'(DEPTH)));
      end else begin
         head_d = head_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= {PW{1'b0}};
         tail_q <= {PW{1'b0}};
         cnt_q  <= {CW{1'b0}};
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   // Entry storage, written at the tail on an accepted push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= MQ_ENTRY_ZERO;
         end
      end else if (do_push_s) begin
         mem_q[tail_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/load_resp.sv
// Load responder: line-buffer lookup with fill bypass, miss queue, single-outstanding memory fetch.
module load_resp
   import load_resp_pkg::*;
#(
   parameter int LB_ENTRIES = 4,
   parameter int MQ_DEPTH   = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   load.ds          ld,
   output logic     mem_req,
   output mem_idx_t mem_req_idx,
   input  logic     mem_gnt,
   input  logic     mem_rsp,
   input  mem_blk_t mem_rsp_blk
);
   localparam int LW = (LB_ENTRIES > 1) ? $clog2(LB_ENTRIES) : 1;

   mem_state_e            state_q, state_d;
   logic [LB_ENTRIES-1:0] lb_vld_q;
   mem_idx_t              lb_tag_q [LB_ENTRIES];
   mem_blk_t              lb_dat_q [LB_ENTRIES];
   logic [LW-1:0]         rep_ptr_q;
   logic                  ans_q;
   lq_idx_t               ans_head_q;
   mem_blk_t              ans_blk_q;

   mq_entry_t     mq_head_s, mq_push_data_s;
   logic          mq_full_s, mq_empty_s, mq_push_s, mq_pop_s;
   logic          rsp_ok_s, byp_hit_s, lb_hit_s, hit_s, fill_match_s;
   logic [LW-1:0] lb_hit_sel_s, fill_sel_s;
   mem_blk_t      hit_blk_s;

   // A response only counts while a request is actually outstanding.
   assign rsp_ok_s       = mem_rsp && (state_q == MEM_WAIT);
   assign mq_pop_s       = rsp_ok_s;
   assign byp_hit_s      = rsp_ok_s && (mq_head_s.mem_idx == ld.qry_mem_idx);
   assign hit_s          = byp_hit_s || lb_hit_s;
   assign mq_push_data_s = '{mem_idx: ld.qry_mem_idx, lq_idx: ld.qry_lq_idx};

   load_miss_fifo #(.DEPTH(MQ_DEPTH)) u_mq (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (mq_push_s),
      .push_data_i (mq_push_data_s),
      .pop_i       (mq_pop_s),
      .full_o      (mq_full_s),
      .empty_o     (mq_empty_s),
      .head_o      (mq_head_s)
   );

   // Tag match of the query and of the filling block against the (pre-fill) line buffer.
   always_comb begin
      lb_hit_s     = 1'b0;
      lb_hit_sel_s = {LW{1'b0}};
      fill_match_s = 1'b0;
      fill_sel_s   = {LW{1'b0}};
      for (int i = 0; i < LB_ENTRIES; i++) begin
         if (!lb_hit_s && lb_vld_q[i] && (lb_tag_q[i] == ld.qry_mem_idx)) begin
            lb_hit_s     = 1'b1;
            lb_hit_sel_s = LW'(i);
         end else begin
            lb_hit_s     = lb_hit_s;
         end
         if (!fill_match_s && lb_vld_q[i] && (lb_tag_q[i] == mq_head_s.mem_idx)) begin
            fill_match_s = 1'b1;
            fill_sel_s   = LW'(i);
         end else begin
            fill_match_s = fill_match_s;
         end
      end
   end

   // Hit data select: the in-flight block wins over the buffered copy.
   always_comb begin
      hit_blk_s = MEM_BLK_ZERO;
      if (byp_hit_s) begin
         hit_blk_s = mem_rsp_blk;
      end else if (lb_hit_s) begin
         hit_blk_s = lb_dat_q[lb_hit_sel_s];
      end else begin
         hit_blk_s = MEM_BLK_ZERO;
      end
   end

   // Query handshake: accept hits always, misses only while the queue has room.
   always_comb begin
      ld.ack     = 1'b0;
      ld.hit     = 1'b0;
      ld.hit_blk = MEM_BLK_ZERO;
      mq_push_s  = 1'b0;
      if (rst_n && ld.qry) begin
         ld.ack     = hit_s || !mq_full_s;
         ld.hit     = hit_s;
         ld.hit_blk = hit_blk_s;
         mq_push_s  = !hit_s && !mq_full_s;
      end else begin
         mq_push_s  = 1'b0;
      end
   end

   assign ld.ack_head = ld.qry_lq_idx;
   assign ld.ans      = ans_q;
   assign ld.ans_head = ans_head_q;
   assign ld.ans_blk  = ans_blk_q;
   assign mem_req     = rst_n && (state_q == MEM_REQ);
   assign mem_req_idx = mq_head_s.mem_idx;

   // Memory FSM next-state: fetch the queue head, one request in flight at a time.
   always_comb begin
      state_d = state_q;
      case (state_q)
         MEM_IDLE: if (!mq_empty_s) state_d = MEM_REQ;  else state_d = MEM_IDLE;
         MEM_REQ:  if (mem_gnt)     state_d = MEM_WAIT; else state_d = MEM_REQ;
         MEM_WAIT: if (mem_rsp)     state_d = MEM_IDLE; else state_d = MEM_WAIT;
         default:  state_d = MEM_IDLE;
      endcase
   end

   // Memory FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MEM_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Registered answer: a one-cycle pulse the cycle after the memory response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ans_q      <= 1'b0;
         ans_head_q <= LQ_IDX_ZERO;
         ans_blk_q  <= MEM_BLK_ZERO;
      end else begin
         ans_q <= rsp_ok_s;
         if (rsp_ok_s) begin
            ans_head_q <= mq_head_s.lq_idx;
            ans_blk_q  <= mem_rsp_blk;
         end
      end
   end

   // Line-buffer fill: refresh a matching entry in place, else replace FIFO-order victim.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lb_vld_q  <= {LB_ENTRIES{1'b0}};
         rep_ptr_q <= {LW{1'b0}};
         for (int i = 0; i < LB_ENTRIES; i++) begin
            lb_tag_q[i] <= MEM_IDX_ZERO;
            lb_dat_q[i] <= MEM_BLK_ZERO;
         end
      end else if (rsp_ok_s) begin
         if (fill_match_s) begin
            lb_dat_q[fill_sel_s] <= mem_rsp_blk;
         end else begin
            lb_vld_q[rep_ptr_q] <= 1'b1;
            lb_tag_q[rep_ptr_q] <= mq_head_s.mem_idx;
            lb_dat_q[rep_ptr_q] <= mem_rsp_blk;
            rep_ptr_q           <= LW'(ring_next(32'(rep_ptr_q), 32'(LB_ENTRIES)));
         end
      end
   end

endmodule

// File: tb/tb_load_resp.sv
// Self-checking bench for load_resp: scoreboard of expected answers, one task per scenario.
module tb_load_resp;
   import load_resp_pkg::*;

   typedef struct packed { lq_idx_t lq; mem_blk_t blk; } exp_t;

   logic     clk, rst_n, mem_req, mem_gnt, mem_rsp;
   mem_idx_t mem_req_idx;
   mem_blk_t mem_rsp_blk;
   int       checks, errors;
   exp_t     sb_q[$];
   mem_idx_t pend_q[$];

   load ld_if();

   load_resp #(.LB_ENTRIES(4), .MQ_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .ld(ld_if), .mem_req(mem_req), .mem_req_idx(mem_req_idx),
      .mem_gnt(mem_gnt), .mem_rsp(mem_rsp), .mem_rsp_blk(mem_rsp_blk)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents the bench's memory model returns for a block index.
   function automatic mem_blk_t blk_of(input mem_idx_t idx);
      blk_of = {8'hB5, idx, ~idx, idx ^ 8'h5A};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_qry(input logic v, input mem_idx_t idx, input lq_idx_t lq);
      ld_if.qry = v; ld_if.qry_mem_idx = idx; ld_if.qry_lq_idx = lq;
   endtask

   // Expected answer for an accepted miss, recorded when the miss is driven.
   task automatic miss_push(input mem_idx_t idx, input lq_idx_t lq);
      sb_q.push_back('{lq: lq, blk: blk_of(idx)});
      pend_q.push_back(idx);
   endtask

   // Memory model: wait for mem_req, grant, respond one idle cycle later; report what was seen.
   task automatic serve(input bit byp_en, input mem_idx_t byp_idx, input lq_idx_t byp_lq,
                        output bit tmo, output mem_idx_t req_idx, output bit req_after_gnt,
                        output bit rsp_ack, output bit rsp_hit, output mem_blk_t rsp_blk,
                        output bit post_ack, output bit ans_v, output lq_idx_t ans_head,
                        output mem_blk_t ans_blk, output bit ans_next);
      tmo = 1'b1; req_idx = 8'h00; req_after_gnt = 1'b1; rsp_ack = 1'b0; rsp_hit = 1'b0;
      rsp_blk = 32'h0; post_ack = 1'b0; ans_v = 1'b0; ans_head = 4'h0; ans_blk = 32'h0; ans_next = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (mem_req === 1'b1) begin tmo = 1'b0; break; end
         step();
      end
      if (!tmo) begin
         req_idx = mem_req_idx;
         mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
         #1 req_after_gnt = mem_req;
         step();
         mem_rsp = 1'b1; mem_rsp_blk = blk_of(req_idx);
         if (byp_en) set_qry(1'b1, byp_idx, byp_lq);
         #1 rsp_ack = ld_if.ack; rsp_hit = ld_if.hit; rsp_blk = ld_if.hit_blk;
         step();
         mem_rsp = 1'b0; mem_rsp_blk = 32'h0;
         if (byp_en) ld_if.qry = 1'b0;
         #1 post_ack = ld_if.ack; ans_v = ld_if.ans; ans_head = ld_if.ans_head; ans_blk = ld_if.ans_blk;
         step();
         #1 ans_next = ld_if.ans;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mem_gnt = 1'b0; mem_rsp = 1'b0; mem_rsp_blk = 32'h0;
      set_qry(1'b1, 8'h33, 4'd2);
      step(); step(); #1;
      checks++; if (ld_if.ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0", ld_if.ack); end
      checks++; if (ld_if.hit !== 1'b0) begin errors++; $display("FAIL rst_hit got=%b exp=0", ld_if.hit); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
      checks++; if ({ld_if.ans, ld_if.ans_head, ld_if.ans_blk} !== {1'b0, 4'h0, 32'h0}) begin
         errors++; $display("FAIL rst_ans got=%b/%h/%h exp=0/0/0", ld_if.ans, ld_if.ans_head, ld_if.ans_blk); end
      checks++; if (ld_if.ack_head !== 4'd2) begin errors++; $display("FAIL rst_ack_head got=%h exp=2", ld_if.ack_head); end
      ld_if.qry = 1'b0;
      step(); rst_n = 1'b1; step();
   endtask

   task automatic test_cold_miss();
      bit tmo, rag, rack, rhit, pack, av, an; mem_idx_t ridx, eidx; mem_blk_t rblk, ab; lq_idx_t ah; exp_t ex;
      set_qry(1'b1, 8'h10, 4'd3); #1;
      checks++; if ({ld_if.ack, ld_if.hit, ld_if.ack_head} !== {1'b1, 1'b0, 4'd3}) begin
         errors++; $display("FAIL cold_qry ack/hit/head got=%b/%b/%h exp=1/0/3", ld_if.ack, ld_if.hit, ld_if.ack_head); end
      miss_push(8'h10, 4'd3);
      step(); ld_if.qry = 1'b0;
      serve(1'b0, 8'h00, 4'h0, tmo, ridx, rag, rack, rhit, rblk, pack, av, ah, ab, an);
      ex = '{lq: 4'h0, blk: 32'h0}; eidx = 8'h00;
      if (sb_q.size() > 0) begin ex = sb_q.pop_front(); eidx = pend_q.pop_front(); end
      checks++; if (tmo || ridx !== eidx) begin errors++; $display("FAIL cold_req timeout=%b idx got=%h exp=%h", tmo, ridx, eidx); end
      checks++; if (rag !== 1'b0) begin errors++; $display("FAIL cold_req_after_gnt got=%b exp=0", rag); end
      checks++; if ({av, ah, ab} !== {1'b1, ex.lq, ex.blk}) begin
         errors++; $display("FAIL cold_ans got=%b/%h/%h exp=1/%h/%h", av, ah, ab, ex.lq, ex.blk); end
      checks++; if (an !== 1'b0) begin errors++; $display("FAIL cold_ans_one_cycle got=%b exp=0", an); end
   endtask

   task automatic test_warm_hit();
      bit saw_req;
      set_qry(1'b1, 8'h10, 4'd5); #1;
      checks++; if ({ld_if.ack, ld_if.hit, ld_if.ack_head} !== {1'b1, 1'b1, 4'd5}) begin
         errors++; $display("FAIL warm_ack/hit/head got=%b/%b/%h exp=1/1/5", ld_if.ack, ld_if.hit, ld_if.ack_head); end
      checks++; if (ld_if.hit_blk !== blk_of(8'h10)) begin
         errors++; $display("FAIL warm_hit_blk got=%h exp=%h", ld_if.hit_blk, blk_of(8'h10)); end
      step(); ld_if.qry = 1'b0;
      saw_req = 1'b0;
      for (int i = 0; i < 5; i++) begin if (mem_req !== 1'b0) saw_req = 1'b1; step(); end
      checks++; if (saw_req !== 1'b0) begin errors++; $display("FAIL warm_no_mem_req got=%b exp=0", saw_req); end
   endtask

   task automatic test_queue_full();
      bit tmo, rag, rack, rhit, pack, av, an; mem_idx_t ridx, eidx; mem_blk_t rblk, ab; lq_idx_t ah; exp_t ex;
      for (int k = 0; k < 4; k++) begin
         set_qry(1'b1, 8'h40 + 8'(k), 4'(k)); #1;
         checks++; if ({ld_if.ack, ld_if.hit} !== 2'b10) begin
            errors++; $display("FAIL full_fill%0d ack/hit got=%b/%b exp=1/0", k, ld_if.ack, ld_if.hit); end
         miss_push(8'h40 + 8'(k), 4'(k));
         step();
      end
      set_qry(1'b1, 8'h44, 4'd4);
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (ld_if.ack !== 1'b0) begin errors++; $display("FAIL full_hold%0d ack got=%b exp=0", k, ld_if.ack); end
         step();
      end
      for (int k = 0; k < 5; k++) begin
         serve(1'b0, 8'h00, 4'h0, tmo, ridx, rag, rack, rhit, rblk, pack, av, ah, ab, an);
         if (k == 0) begin
            checks++; if (rack !== 1'b0) begin errors++; $display("FAIL full_ack_pop_cycle got=%b exp=0", rack); end
            checks++; if (pack !== 1'b1) begin errors++; $display("FAIL full_ack_after_pop got=%b exp=1", pack); end
            if (pack === 1'b1) miss_push(8'h44, 4'd4);
            ld_if.qry = 1'b0;
         end
         ex = '{lq: 4'h0, blk: 32'h0}; eidx = 8'h00;
         if (sb_q.size() > 0) begin ex = sb_q.pop_front(); eidx = pend_q.pop_front(); end
         checks++; if (tmo || ridx !== eidx) begin errors++; $display("FAIL full_req%0d timeout=%b idx got=%h exp=%h", k, tmo, ridx, eidx); end
         checks++; if ({av, ah, ab} !== {1'b1, ex.lq, ex.blk}) begin
            errors++; $display("FAIL full_ans%0d got=%b/%h/%h exp=1/%h/%h", k, av, ah, ab, ex.lq, ex.blk); end
      end
   endtask

   task automatic test_bypass();
      bit tmo, rag, rack, rhit, pack, av, an, saw_req; mem_idx_t ridx, eidx; mem_blk_t rblk, ab; lq_idx_t ah; exp_t ex;
      set_qry(1'b1, 8'h20, 4'd6); #1;
      checks++; if ({ld_if.ack, ld_if.hit} !== 2'b10) begin
         errors++; $display("FAIL byp_miss ack/hit got=%b/%b exp=1/0", ld_if.ack, ld_if.hit); end
      miss_push(8'h20, 4'd6);
      step(); ld_if.qry = 1'b0;
      serve(1'b1, 8'h20, 4'd7, tmo, ridx, rag, rack, rhit, rblk, pack, av, ah, ab, an);
      ex = '{lq: 4'h0, blk: 32'h0}; eidx = 8'h00;
      if (sb_q.size() > 0) begin ex = sb_q.pop_front(); eidx = pend_q.pop_front(); end
      checks++; if (tmo || ridx !== eidx) begin errors++; $display("FAIL byp_req timeout=%b idx got=%h exp=%h", tmo, ridx, eidx); end
      checks++; if ({rack, rhit, rblk} !== {1'b1, 1'b1, blk_of(8'h20)}) begin
         errors++; $display("FAIL byp_hit ack/hit/blk got=%b/%b/%h exp=1/1/%h", rack, rhit, rblk, blk_of(8'h20)); end
      checks++; if ({av, ah, ab} !== {1'b1, ex.lq, ex.blk}) begin
         errors++; $display("FAIL byp_ans got=%b/%h/%h exp=1/%h/%h", av, ah, ab, ex.lq, ex.blk); end
      saw_req = 1'b0;
      for (int i = 0; i < 6; i++) begin if (mem_req !== 1'b0 || ld_if.ans !== 1'b0) saw_req = 1'b1; step(); end
      checks++; if (saw_req !== 1'b0) begin errors++; $display("FAIL byp_not_enqueued got=%b exp=0", saw_req); end
   endtask

   task automatic test_replacement();
      bit tmo, rag, rack, rhit, pack, av, an; mem_idx_t ridx, eidx; mem_blk_t rblk, ab; lq_idx_t ah; exp_t ex;
      for (int k = 0; k < 6; k++) begin
         // Five distinct fills, then a refetch of the first (evicted) block.
         set_qry(1'b1, (k < 5) ? 8'h50 + 8'(k) : 8'h50, 4'(8 + k)); #1;
         checks++; if ({ld_if.ack, ld_if.hit} !== 2'b10) begin
            errors++; $display("FAIL repl_miss%0d ack/hit got=%b/%b exp=1/0", k, ld_if.ack, ld_if.hit); end
         miss_push(ld_if.qry_mem_idx, ld_if.qry_lq_idx);
         step(); ld_if.qry = 1'b0;
         serve(1'b0, 8'h00, 4'h0, tmo, ridx, rag, rack, rhit, rblk, pack, av, ah, ab, an);
         ex = '{lq: 4'h0, blk: 32'h0}; eidx = 8'h00;
         if (sb_q.size() > 0) begin ex = sb_q.pop_front(); eidx = pend_q.pop_front(); end
         checks++; if (tmo || ridx !== eidx || {av, ah, ab} !== {1'b1, ex.lq, ex.blk}) begin
            errors++; $display("FAIL repl_ans%0d req=%h/%h ans got=%b/%h/%h exp=1/%h/%h", k, ridx, eidx, av, ah, ab, ex.lq, ex.blk); end
         if (k == 4) begin
            for (int j = 1; j < 5; j++) begin
               set_qry(1'b1, 8'h50 + 8'(j), 4'd1); #1;
               checks++; if ({ld_if.ack, ld_if.hit, ld_if.hit_blk} !== {1'b1, 1'b1, blk_of(8'h50 + 8'(j))}) begin
                  errors++; $display("FAIL repl_hit%0d got=%b/%b/%h exp=1/1/%h", j, ld_if.ack, ld_if.hit, ld_if.hit_blk, blk_of(8'h50 + 8'(j))); end
               step(); ld_if.qry = 1'b0;
            end
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      bit tmo, bad;
      set_qry(1'b1, 8'h60, 4'd9); step(); ld_if.qry = 1'b0;
      tmo = 1'b1;
      for (int i = 0; i < 20; i++) begin if (mem_req === 1'b1) begin tmo = 1'b0; break; end step(); end
      checks++; if (tmo) begin errors++; $display("FAIL rmw_req_timeout got=0 exp=1"); end
      mem_gnt = 1'b1; step(); mem_gnt = 1'b0; step();
      rst_n = 1'b0; set_qry(1'b1, 8'h60, 4'd9); #1;
      checks++; if ({ld_if.ack, ld_if.hit, mem_req} !== 3'b000) begin
         errors++; $display("FAIL rmw_in_reset ack/hit/req got=%b/%b/%b exp=0/0/0", ld_if.ack, ld_if.hit, mem_req); end
      ld_if.qry = 1'b0; sb_q.delete(); pend_q.delete();
      step(); rst_n = 1'b1; step();
      mem_rsp = 1'b1; mem_rsp_blk = blk_of(8'h60); step(); mem_rsp = 1'b0; mem_rsp_blk = 32'h0; #1;
      checks++; if (ld_if.ans !== 1'b0) begin errors++; $display("FAIL rmw_stray_ans got=%b exp=0", ld_if.ans); end
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin if (mem_req !== 1'b0 || ld_if.ans !== 1'b0) bad = 1'b1; step(); end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rmw_queue_empty got=%b exp=0", bad); end
      set_qry(1'b1, 8'h52, 4'd2); #1;
      checks++; if (ld_if.hit !== 1'b0) begin errors++; $display("FAIL rmw_lb_cleared hit got=%b exp=0", ld_if.hit); end
      ld_if.qry = 1'b0; step();
   endtask

   initial begin
      checks = 0; errors = 0;
      test_reset();
      test_cold_miss();
      test_warm_hit();
      test_queue_full();
      test_bypass();
      test_replacement();
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_resp.md
LOAD_RESP -- requirements
Module: load_resp

Interface
REQ-001 SHALL have parameter LB_ENTRIES, default 4: number of fully-associative line-buffer entries.
REQ-002 SHALL have parameter MQ_DEPTH, default 4: number of miss-queue entries (power of two).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ld  load.ds  -  the load query/ack/hit/answer interface, responder side.
REQ-006 SHALL have port mem_req  output  1  memory block-read request, held until granted.
REQ-007 SHALL have port mem_req_idx  output  mem_idx_t  block index being requested.
REQ-008 SHALL have port mem_gnt  input  1  memory accepts mem_req this cycle.
REQ-009 SHALL have port mem_rsp  input  1  read data valid, one-cycle pulse, in request order.
REQ-010 SHALL have port mem_rsp_blk  input  mem_blk_t  returned block data.

Function
REQ-011 SHALL treat a query as transferred in a cycle where ld.qry and ld.ack are both 1; LQ holds qry, qry_mem_idx and qry_lq_idx stable until then.
REQ-012 SHALL drive ld.ack combinationally: 1 when ld.qry=1 and (lookup hits or miss-queue count < MQ_DEPTH), else 0.
REQ-013 SHALL drive ld.ack_head = ld.qry_lq_idx in every cycle.
REQ-014 SHALL look up qry_mem_idx against all valid line-buffer tags plus a bypass: mem_rsp=1 with head miss-queue mem_idx equal to qry_mem_idx.
REQ-015 SHALL, on hit, drive ld.hit=1 and ld.hit_blk = matching data in the same cycle as ack; bypass data = mem_rsp_blk and takes priority over buffer data.
REQ-016 SHALL, on an acked miss, push {qry_mem_idx, qry_lq_idx} into the miss queue; ld.hit=0 that cycle.
REQ-017 SHALL not merge duplicate misses; each is queued and fetched separately.
REQ-018 SHALL judge queue full on pre-edge count only; a same-cycle pop does not free space for a push.
REQ-019 SHALL run a memory FSM: IDLE -> REQ when queue non-empty; REQ drives mem_req=1, mem_req_idx = head mem_idx; REQ -> WAIT on mem_gnt; WAIT -> IDLE on mem_rsp.
REQ-020 SHALL keep one memory request outstanding at most.
REQ-021 SHALL, on mem_rsp in WAIT, pop the head and register: ld.ans=1, ld.ans_head = head lq_idx, ld.ans_blk = mem_rsp_blk, visible the next cycle for exactly one cycle.
REQ-022 SHALL, on the same mem_rsp, write {head mem_idx, mem_rsp_blk} into the line buffer: an existing matching entry is overwritten in place; otherwise the FIFO-replacement pointer entry is overwritten and the pointer advances modulo LB_ENTRIES.
REQ-023 SHALL let lookups in the cycle of a fill see pre-fill buffer contents; the bypass in REQ-014 covers the in-flight block.
REQ-024 SHALL allow ans and hit in the same cycle, for different lq indices.
REQ-025 SHALL ignore mem_rsp outside WAIT.
REQ-026 SHALL wrap miss-queue head/tail pointers modulo MQ_DEPTH.

Reset
REQ-027 SHALL, while rst_n=0, clear the FSM to IDLE, miss queue to empty, all line-buffer valid bits, the replacement pointer, and ld.ans; ans_head and ans_blk to 0.
REQ-028 SHALL force ld.ack=0, ld.hit=0 and mem_req=0 while rst_n=0.
REQ-029 SHALL discard an in-flight memory request on reset; a later stray mem_rsp is ignored per REQ-025.

Structure
REQ-030 SHALL take bool, mem_idx_t, lq_idx_t and mem_blk_t from the shared package; the miss-queue entry struct {mem_idx_t, lq_idx_t} SHALL also live there.
REQ-031 SHALL implement the miss queue as one sub-module, load_miss_fifo (push/pop/full/empty/head).

Verification
REQ-032 Cold miss: qry idx=0x10, lq=3 -> ack=1, hit=0; mem_req idx=0x10; gnt, then rsp blk=B -> next cycle ans=1, ans_head=3, ans_blk=B.
REQ-033 Warm hit: after REQ-032, qry idx=0x10, lq=5 -> same cycle ack=1, hit=1, hit_blk=B, ack_head=5, no mem_req.
REQ-034 Queue full: 4 misses with mem_gnt=0, fifth qry -> ack=0 held; ack=0 also in the mem_rsp pop cycle, ack=1 the cycle after.
REQ-035 Bypass: qry idx=0x20 in the mem_rsp cycle for head idx=0x20 -> hit=1, hit_blk = mem_rsp_blk, not enqueued.
REQ-036 Replacement: fill 5 distinct idx with LB_ENTRIES=4 -> first idx misses again, idx 2-5 hit.
REQ-037 Reset mid-WAIT: rst_n low then high, stray mem_rsp -> no ans, queue empty, mem_req=0.
